// File: rtl/dmem_access_pkg.sv
// Shared types for the data-memory access stage: memory opcodes, pipeline bus,
// load-controller descriptor and access FSM states.
package dmem_access_pkg;

   localparam int DMEM_TIMEOUT_W = 8;
   localparam int LOAD_PRFX      = 3;

   localparam logic [1:0] SZ_BYTE = 2'd1;
   localparam logic [1:0] SZ_HALF = 2'd2;
   localparam logic [1:0] SZ_WORD = 2'd3;

   // Bit 3 marks loads, bit 2 marks zero-extending loads, bits [1:0] give the size.
   typedef enum logic [3:0] {
      MEM_NOP = 4'b0000,
      MEM_SB  = 4'b0001,
      MEM_SH  = 4'b0010,
      MEM_SW  = 4'b0011,
      MEM_LB  = 4'b1001,
      MEM_LH  = 4'b1010,
      MEM_LW  = 4'b1011,
      MEM_LBU = 4'b1101,
      MEM_LHU = 4'b1110
   } mem_op_e;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GNT,
      WAIT_RSP,
      DONE
   } dmem_state_e;

   typedef struct packed {
      mem_op_e     mem_op;
      logic        rf_wr_en;
      logic [4:0]  rd_addr;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
   } pipeline_bus_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [1:0]  offset;
   } mem_cntrl_bus_t;

endpackage

// File: rtl/dmem_access_align.sv
// Lane alignment for data memory: byte enables, store replication, read shift.
// DMEM_MISALIGN_TRAP_EN: flag misaligned accesses instead of forcing alignment.
module dmem_align
   import dmem_access_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic [31:0] rs2_data,
   input  logic [31:0] rdata,
   output logic [1:0]  offset_eff,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] rdata_shift,
   output logic        misaligned
);

   always_comb begin
      misaligned = 1'b0;
      offset_eff = offset;
`ifdef DMEM_MISALIGN_TRAP_EN
      case (size)
         SZ_HALF: misaligned = offset[0];
         SZ_WORD: misaligned = (offset != 2'd0);
         default: misaligned = 1'b0;
      endcase
`else
      case (size)
         SZ_HALF: offset_eff = {offset[1], 1'b0};
         SZ_WORD: offset_eff = 2'd0;
         default: offset_eff = offset;
      endcase
`endif
      case (size)
         SZ_BYTE: begin
            be    = 4'b0001 << offset_eff;
            wdata = {4{rs2_data[7:0]}};
         end
         SZ_HALF: begin
            be    = 4'b0011 << offset_eff;
            wdata = {2{rs2_data[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = rs2_data;
         end
      endcase
      rdata_shift = rdata >> {offset_eff, 3'b000};
   end

endmodule

// File: rtl/dmem_access.sv
// Data-memory access stage: req/gnt/rvalid handshake with pipeline stall and timeout.
// Misalignment behaviour selected by DMEM_MISALIGN_TRAP_EN (see dmem_align).
module dmem_access
   import dmem_access_pkg::*;
#(
   parameter int unsigned RSP_TIMEOUT = 255
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  pipeline_bus_t  bus_i,
   output logic           stall_o,
   output logic           dmem_req_o,
   output logic           dmem_we_o,
   output logic [3:0]     dmem_be_o,
   output logic [31:0]    dmem_addr_o,
   output logic [31:0]    dmem_wdata_o,
   input  logic           dmem_gnt_i,
   input  logic           dmem_rvalid_i,
   input  logic [31:0]    dmem_rdata_i,
   output pipeline_bus_t  bus_o,
   output mem_cntrl_bus_t mem_cntrl_o,
   output logic [31:0]    rdata_o,
   output logic           fault_o
);

   dmem_state_e               state_reg;
   logic [DMEM_TIMEOUT_W-1:0] cnt_reg;
   pipeline_bus_t             lat_bus_reg;
   mem_cntrl_bus_t            desc_reg;
   logic                      fault_reg;
   logic [31:0]               rdata_reg;

   logic          in_idle, is_mem, is_store, timeout;
   logic [31:0]   ea_in, ea_lat, ea, src_rs2;
   logic [1:0]    src_size, al_offset;
   logic [3:0]    al_be;
   logic [31:0]   al_wdata, al_rdata;
   logic          al_misaligned;
   pipeline_bus_t done_bus;

   // Once an access is accepted the align logic works from the latched
   // instruction, so it never depends on upstream holding bus_i.
   assign in_idle  = (state_reg == IDLE);
   assign ea_in    = bus_i.rs1_data + bus_i.imm;
   assign ea_lat   = lat_bus_reg.rs1_data + lat_bus_reg.imm;
   assign ea       = in_idle ? ea_in : ea_lat;
   assign src_size = in_idle ? bus_i.mem_op[1:0] : lat_bus_reg.mem_op[1:0];
   assign src_rs2  = in_idle ? bus_i.rs2_data : lat_bus_reg.rs2_data;
   assign is_mem   = (bus_i.mem_op != MEM_NOP);
   assign is_store = ~bus_i.mem_op[LOAD_PRFX];
   assign timeout  = (RSP_TIMEOUT != 0) && (32'(cnt_reg) == RSP_TIMEOUT - 1);

   assign stall_o = rst_ni & ((in_idle & is_mem) | (state_reg == WAIT_GNT) | (state_reg == WAIT_RSP));

   always_comb begin
      done_bus          = lat_bus_reg;
      done_bus.rf_wr_en = lat_bus_reg.rf_wr_en & ~fault_reg;
   end

   dmem_align u_align (
      .size        (src_size),
      .offset      (ea[1:0]),
      .rs2_data    (src_rs2),
      .rdata       (dmem_rdata_i),
      .offset_eff  (al_offset),
      .be          (al_be),
      .wdata       (al_wdata),
      .rdata_shift (al_rdata),
      .misaligned  (al_misaligned)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         lat_bus_reg  <= '0;
         desc_reg     <= '0;
         fault_reg    <= 1'b0;
         rdata_reg    <= '0;
         dmem_req_o   <= 1'b0;
         dmem_we_o    <= 1'b0;
         dmem_be_o    <= '0;
         dmem_addr_o  <= '0;
         dmem_wdata_o <= '0;
         bus_o        <= '0;
         mem_cntrl_o  <= '0;
         rdata_o      <= '0;
         fault_o      <= 1'b0;
      end else begin
         fault_o <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (is_mem) begin
                  bus_o       <= '0;
                  lat_bus_reg <= bus_i;
                  desc_reg    <= '{addr: {ea[31:2], 2'b00}, be: al_be, we: is_store, offset: al_offset};
                  rdata_reg   <= '0;
                  cnt_reg     <= '0;
                  fault_reg   <= al_misaligned;
                  if (al_misaligned) begin
                     state_reg <= DONE;
                  end else begin
                     dmem_req_o   <= 1'b1;
                     dmem_we_o    <= is_store;
                     dmem_be_o    <= al_be;
                     dmem_addr_o  <= {ea[31:2], 2'b00};
                     dmem_wdata_o <= al_wdata;
                     state_reg    <= WAIT_GNT;
                  end
               end else begin
                  bus_o <= bus_i;
               end
            end
            WAIT_GNT: begin
               bus_o <= '0;
               if (dmem_gnt_i) begin
                  dmem_req_o <= 1'b0;
                  cnt_reg    <= '0;
                  if (desc_reg.we) begin
                     state_reg <= DONE;
                  end else if (dmem_rvalid_i) begin
                     rdata_reg <= al_rdata;
                     state_reg <= DONE;
                  end else begin
                     state_reg <= WAIT_RSP;
                  end
               end else if (timeout) begin
                  dmem_req_o <= 1'b0;
                  fault_reg  <= 1'b1;
                  state_reg  <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            WAIT_RSP: begin
               bus_o <= '0;
               if (dmem_rvalid_i) begin
                  rdata_reg <= al_rdata;
                  state_reg <= DONE;
               end else if (timeout) begin
                  fault_reg <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            DONE: begin
               bus_o       <= done_bus;
               mem_cntrl_o <= desc_reg;
               rdata_o     <= rdata_reg;
               fault_o     <= fault_reg;
               state_reg   <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access.sv
// Directed and random bench for dmem_access against a byte-lane reference model.
// Expectations follow DMEM_MISALIGN_TRAP_EN when it is defined.
module tb_dmem_access;
   import dmem_access_pkg::*;

   localparam int TMO = 255;

   logic           clk_i = 1'b0;
   logic           rst_ni = 1'b0;
   pipeline_bus_t  bus_i = '0;
   logic           stall_o;
   logic           dmem_req_o, dmem_we_o;
   logic [3:0]     dmem_be_o;
   logic [31:0]    dmem_addr_o, dmem_wdata_o;
   logic           dmem_gnt_i = 1'b0;
   logic           dmem_rvalid_i = 1'b0;
   logic [31:0]    dmem_rdata_i = '0;
   pipeline_bus_t  bus_o;
   mem_cntrl_bus_t mem_cntrl_o;
   logic [31:0]    rdata_o;
   logic           fault_o;

   int tests = 0;
   int fails = 0;

   dmem_access #(.RSP_TIMEOUT(TMO)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .bus_i(bus_i), .stall_o(stall_o),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
      .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
      .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
      .bus_o(bus_o), .mem_cntrl_o(mem_cntrl_o), .rdata_o(rdata_o), .fault_o(fault_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_stall"}, 128'(stall_o), 128'(0));
      chk({tag, "_req"},   128'(dmem_req_o), 128'(0));
      chk({tag, "_we"},    128'(dmem_we_o), 128'(0));
      chk({tag, "_be"},    128'(dmem_be_o), 128'(0));
      chk({tag, "_addr"},  128'(dmem_addr_o), 128'(0));
      chk({tag, "_wdata"}, 128'(dmem_wdata_o), 128'(0));
      chk({tag, "_bus"},   128'(bus_o), 128'(0));
      chk({tag, "_mc"},    128'(mem_cntrl_o), 128'(0));
      chk({tag, "_rdata"}, 128'(rdata_o), 128'(0));
      chk({tag, "_fault"}, 128'(fault_o), 128'(0));
   endtask

   // Non-memory instruction, with stray gnt/rvalid that must be ignored.
   task automatic alu_txn(input logic [31:0] a, input logic [31:0] b);
      pipeline_bus_t ins;
      ins = '0;
      ins.mem_op   = MEM_NOP;
      ins.rf_wr_en = 1'b1;
      ins.rd_addr  = 5'($urandom);
      ins.rs1_data = a;
      ins.rs2_data = $urandom;
      ins.imm      = b;
      @(negedge clk_i);
      bus_i = ins;
      dmem_gnt_i = 1'($urandom);
      dmem_rvalid_i = 1'($urandom);
      #1;
      chk("alu_stall", 128'(stall_o), 128'(0));
      @(negedge clk_i);
      chk("alu_bus", 128'(bus_o), 128'(ins));
      chk("alu_req", 128'(dmem_req_o), 128'(0));
      chk("alu_fault", 128'(fault_o), 128'(0));
      dmem_gnt_i = 1'b0;
      dmem_rvalid_i = 1'b0;
      bus_i = '0;
      $display("[TB] alu a=%08h b=%08h", a, b);
   endtask

   // One memory access; gnt after gnt_wait idle cycles, rvalid rsp_wait cycles after gnt.
   task automatic mem_txn(input mem_op_e op, input logic [31:0] rs1, input logic [31:0] imm,
                          input logic [31:0] rs2, input logic [31:0] rd_raw,
                          input int gnt_wait, input int rsp_wait);
      pipeline_bus_t  ins, exp_bus;
      mem_cntrl_bus_t exp_mc;
      logic [31:0]    ea, exp_wdata, exp_rdata;
      logic [3:0]     exp_be;
      int             nb, off, eoff, n;
      bit             is_load, mis, trap, tmo;

      is_load = op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
      nb = (op inside {MEM_SB, MEM_LB, MEM_LBU}) ? 1 : (op inside {MEM_SH, MEM_LH, MEM_LHU}) ? 2 : 4;
      ea  = rs1 + imm;
      off = int'(ea % 4);
      mis = (off % nb) != 0;
`ifdef DMEM_MISALIGN_TRAP_EN
      trap = mis;
      eoff = off;
`else
      trap = 1'b0;
      eoff = off - (off % nb);
`endif
      tmo = !trap && (gnt_wait >= TMO);
      exp_be = (nb == 4) ? 4'hF : 4'(((1 << nb) - 1) << eoff);
      exp_wdata = (nb == 1) ? rs2[7:0] * 32'h01010101 : (nb == 2) ? rs2[15:0] * 32'h00010001 : rs2;
      exp_rdata = rd_raw >> (8 * eoff);

      ins = '0;
      ins.mem_op   = op;
      ins.rf_wr_en = is_load;
      ins.rd_addr  = 5'($urandom);
      ins.rs1_data = rs1;
      ins.rs2_data = rs2;
      ins.imm      = imm;
      exp_bus = ins;
      if (trap || tmo) exp_bus.rf_wr_en = 1'b0;
      exp_mc.addr   = ea - 32'(off);
      exp_mc.be     = exp_be;
      exp_mc.we     = !is_load;
      exp_mc.offset = 2'(eoff);

      @(negedge clk_i);
      bus_i = ins;
      dmem_gnt_i = 1'b0;
      dmem_rvalid_i = 1'b0;
      #1;
      chk("accept_stall", 128'(stall_o), 128'(1));
      @(negedge clk_i);
      if (!trap) begin
         chk("gnt_req", 128'(dmem_req_o), 128'(1));
         chk("gnt_stall", 128'(stall_o), 128'(1));
         chk("gnt_addr", 128'(dmem_addr_o), 128'(exp_mc.addr));
         chk("gnt_be", 128'(dmem_be_o), 128'(exp_be));
         chk("gnt_we", 128'(dmem_we_o), 128'(!is_load));
         if (!is_load) chk("gnt_wdata", 128'(dmem_wdata_o), 128'(exp_wdata));
         chk("gnt_bubble", 128'({bus_o.mem_op, bus_o.rf_wr_en}), 128'({MEM_NOP, 1'b0}));
         n = tmo ? TMO - 1 : gnt_wait;
         for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            chk("gnt_hold", 128'({dmem_req_o, stall_o, dmem_addr_o}), 128'({2'b11, exp_mc.addr}));
         end
         if (!tmo) begin
            dmem_gnt_i = 1'b1;
            if (is_load && rsp_wait == 0) begin
               dmem_rvalid_i = 1'b1;
               dmem_rdata_i  = rd_raw;
            end else begin
               dmem_rdata_i = $urandom;
            end
            @(negedge clk_i);
            dmem_gnt_i = 1'b0;
            dmem_rvalid_i = 1'b0;
            if (is_load && rsp_wait > 0) begin
               chk("rsp_req", 128'(dmem_req_o), 128'(0));
               chk("rsp_stall", 128'(stall_o), 128'(1));
               for (int i = 1; i < rsp_wait; i++) begin
                  dmem_rdata_i = $urandom;
                  @(negedge clk_i);
               end
               dmem_rvalid_i = 1'b1;
               dmem_rdata_i  = rd_raw;
               @(negedge clk_i);
               dmem_rvalid_i = 1'b0;
               dmem_rdata_i  = $urandom;
            end
         end else begin
            @(negedge clk_i);
         end
      end
      chk("done_stall", 128'(stall_o), 128'(0));
      chk("done_req", 128'(dmem_req_o), 128'(0));
      chk("done_bubble", 128'({bus_o.mem_op, bus_o.rf_wr_en}), 128'({MEM_NOP, 1'b0}));
      bus_i = '0;
      @(negedge clk_i);
      chk("out_bus", 128'(bus_o), 128'(exp_bus));
      chk("out_mc", 128'(mem_cntrl_o), 128'(exp_mc));
      chk("out_fault", 128'(fault_o), 128'(trap || tmo));
      if (is_load && !trap && !tmo) chk("out_rdata", 128'(rdata_o), 128'(exp_rdata));
      @(negedge clk_i);
      chk("fault_pulse", 128'(fault_o), 128'(0));
      $display("[TB] %s ea=%08h gw=%0d rw=%0d be=%b addr=%08h fault=%0b rdata=%08h",
               op.name(), ea, gnt_wait, rsp_wait, mem_cntrl_o.be, mem_cntrl_o.addr, trap || tmo, rdata_o);
   endtask

   mem_op_e ops [8] = '{MEM_SB, MEM_SH, MEM_SW, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};

   initial begin
      repeat (3) @(negedge clk_i);
      chk_reset_outputs("rst");
      rst_ni = 1'b1;

      alu_txn(32'h0000_0010, 32'h0000_0020);
      mem_txn(MEM_SW, 32'h0000_1000, 32'd4, 32'hDEAD_BEEF, 32'h0, 0, 0);
      mem_txn(MEM_SB, 32'h0000_2000, 32'd3, 32'h0000_00A5, 32'h0, 0, 0);
      mem_txn(MEM_LH, 32'h0000_3000, 32'd2, 32'h0, 32'h1234_5678, 0, 2);
      mem_txn(MEM_LW, 32'h0000_4000, 32'd1, 32'h0, 32'hCAFE_F00D, 0, 1);
      mem_txn(MEM_LBU, 32'h0000_5000, 32'd3, 32'h0, 32'h89AB_CDEF, 1, 0);
      mem_txn(MEM_SH, 32'hFFFF_FFFE, 32'd4, 32'h0000_BEEF, 32'h0, 2, 0);
      mem_txn(MEM_SW, 32'h0000_6000, 32'd0, 32'h1111_2222, 32'h0, TMO, 0);
      mem_txn(MEM_LW, 32'h0000_7000, 32'd8, 32'h0, 32'h0BAD_F00D, 0, 1);

      // Reset asserted while a load waits for its response.
      @(negedge clk_i);
      bus_i = '{mem_op: MEM_LW, rf_wr_en: 1'b1, rd_addr: 5'd3, rs1_data: 32'h8000, rs2_data: 32'h0, imm: 32'h4};
      @(negedge clk_i);
      dmem_gnt_i = 1'b1;
      @(negedge clk_i);
      dmem_gnt_i = 1'b0;
      chk("pre_rst_stall", 128'(stall_o), 128'(1));
      #2 rst_ni = 1'b0;
      #1 chk_reset_outputs("midrst");
      @(negedge clk_i);
      bus_i = '0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      mem_txn(MEM_LW, 32'h0000_8000, 32'd4, 32'h0, 32'h5566_7788, 0, 1);

      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 3) == 0)
            alu_txn($urandom, $urandom);
         else
            mem_txn(ops[$urandom_range(0, 7)], $urandom, $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dmem_access.md
# dmem_access

Data-memory access stage of the core pipeline, directly upstream of the load-result path. Takes the execute-stage `pipeline_bus_t`, computes the effective address, and generates byte enables and lane-replicated store data. It runs a req/gnt/rvalid handshake against data memory and stalls the pipeline while an access is outstanding. It then presents a registered `pipeline_bus_t`, the `mem_cntrl_bus_t` descriptor and offset-aligned read data to the load controller.

## Interface
- `RSP_TIMEOUT`, 255: maximum cycles in WAIT_GNT or WAIT_RSP before abort; 0 disables the timeout.
- `clk_i` in 1: single core clock, rising edge.
- `rst_ni` in 1: reset, asynchronous assert, active-low.
- `bus_i` in `pipeline_bus_t`: instruction from execute. Held stable by upstream while `stall_o`=1.
- `stall_o` out 1: freezes all upstream stages.
- `dmem_req_o` out 1: request valid.
- `dmem_we_o` out 1: 1 = store.
- `dmem_be_o` out 4: byte enables.
- `dmem_addr_o` out 32: word-aligned address, bits [1:0]=0.
- `dmem_wdata_o` out 32: store data, lane-replicated.
- `dmem_gnt_i` in 1: request accepted in this cycle.
- `dmem_rvalid_i` in 1: read data valid.
- `dmem_rdata_i` in 32: raw read word.
- `bus_o` out `pipeline_bus_t`: registered bus to the load controller.
- `mem_cntrl_o` out `mem_cntrl_bus_t`: registered {addr[31:0], be[3:0], we, offset[1:0]} of the completed access.
- `rdata_o` out 32: `dmem_rdata_i >> (8*offset)`, registered. Byte 0 of the requested datum is in bits [7:0].
- `fault_o` out 1: one-cycle pulse, valid with `bus_o`; set on misalignment trap or timeout.

## Operation
- Effective address: `ea = rs1_data + imm`, 32-bit modulo (wrap at 2^32). `offset = ea[1:0]`.
- Memory op detection: `mem_op != MEM_NOP`. Load vs store is given by the `LOAD_PRFX` bit.
- Byte enables:
  - Byte ops: `0001 << offset`.
  - Half ops: `0011 << offset`.
  - Word ops: `1111`.
- Store data:
  - SB: `{4{rs2_data[7:0]}}`.
  - SH: `{2{rs2_data[15:0]}}`.
  - SW: `rs2_data`.
- FSM states:
  - IDLE:
    - Non-mem instruction: registered into `bus_o` next cycle, no stall.
    - Mem instruction: latch the descriptor, `stall_o`=1 combinationally in the same cycle, go to WAIT_GNT.
  - WAIT_GNT: `dmem_req_o`=1, with address, we, be and wdata held constant.
    - On `dmem_gnt_i`: a store goes to DONE; a load goes to WAIT_RSP.
  - WAIT_RSP: `dmem_req_o`=0.
    - On `dmem_rvalid_i`: capture the shifted rdata, go to DONE.
    - `dmem_rvalid_i` in the same cycle as the grant is legal. The load then goes straight from WAIT_GNT to DONE.
  - DONE: `bus_o` <= latched bus, `mem_cntrl_o` <= descriptor, `stall_o`=0, return to IDLE. Upstream advances on this edge.
- While stalled, `bus_o` carries a bubble: `mem_op`=MEM_NOP, `rf_wr_en`=0, other fields don't-care.
- Timeout: a counter is cleared on entry to WAIT_GNT and WAIT_RSP. When it reaches `RSP_TIMEOUT`:
  - drop `dmem_req_o`;
  - go to DONE with `rf_wr_en` cleared and `fault_o`=1.
- Unexpected `dmem_rvalid_i`/`dmem_gnt_i` in IDLE or DONE is ignored.

## Timing
- Reset values:
  - `stall_o`=0.
  - `dmem_req_o`=0, `dmem_we_o`=0, `dmem_be_o`=0, `dmem_addr_o`=0, `dmem_wdata_o`=0.
  - `bus_o` is a bubble.
  - `mem_cntrl_o`=0, `rdata_o`=0, `fault_o`=0.
  - FSM in IDLE, counter at 0.
- Reset mid-access abandons the access immediately. Memory must tolerate the dropped request.
- Latency:
  - Non-mem instruction: 1 cycle.
  - Store with immediate grant: 3 cycles (IDLE→WAIT_GNT→DONE→`bus_o`).
  - Load with grant and rvalid in consecutive cycles: 4 cycles.
- Back-to-back mem ops: the next op is sampled in the IDLE cycle after DONE. There is no bypass.
- `dmem_req_o` never deasserts before `dmem_gnt_i`, except on timeout or reset.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - Misaligned access (half with `offset[0]`=1, word with `offset`≠0) issues no request.
  - The FSM goes IDLE→DONE with `rf_wr_en`=0 and `fault_o`=1.
- `DMEM_MISALIGN_TRAP_EN` undefined:
  - Offset is forced aligned: half clears bit 0, word clears [1:0].
  - Enables are computed from the forced offset, and the access proceeds normally.
  - `fault_o` is set only by timeout.

## Structure
- `core` package gains:
  - `dmem_state_e` (IDLE, WAIT_GNT, WAIT_RSP, DONE);
  - `mem_cntrl_bus_t` field definitions;
  - `DMEM_TIMEOUT_W` constant.
- One natural sub-module: `dmem_align`, combinational. It takes `mem_op`, `offset`, `rs2_data` and `dmem_rdata_i`, and produces `be`, `wdata`, shifted rdata and the misaligned flag.

## Test plan
- SW rs1=0x1000, imm=4, rs2=0xDEADBEEF, gnt in the first WAIT_GNT cycle -> addr 0x1004, be 1111, wdata 0xDEADBEEF, `stall_o` high 2 cycles, `bus_o` valid in cycle 3.
- SB ea=0x2003, rs2=0xA5 -> be 1000, wdata 0xA5A5A5A5, addr 0x2000.
- LH ea=0x3002, rdata=0x12345678, rvalid 2 cycles after gnt -> `rdata_o`=0x00001234, `mem_cntrl_o.offset`=2, `bus_o` mem_op LH.
- LW ea=0x4001:
  - with the macro: no `dmem_req_o`, `fault_o`=1, `rf_wr_en`=0;
  - without the macro: addr 0x4000, be 1111.
- Grant withheld 255 cycles -> req dropped, `fault_o`=1, `rf_wr_en`=0, stall released.
- `rst_ni` low during WAIT_RSP -> all outputs at reset values immediately; the next LW after release completes normally.
